// File: rtl/shift_pkg.sv
// Shared types for the sequential shift engine.
// Mode and FSM state encodings used by shift_seq and shift_step.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL,
        SH_LSR,
        SH_ASR,
        SH_ROL
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_e;

    localparam int SHIFT_N_DEF = 7;

endpackage

// File: rtl/shift_step.sv
// Single-bit combinational shift of a [N:0] word by mode.
// Rotate exists only with SHIFT_SEQ_ROTATE_EN; otherwise mode 11 acts as LSL.
module shift_step
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N_DEF
) (
    input  logic [N:0] d,
    input  logic [1:0] mode,
    output logic [N:0] q
);

    always_comb begin
        q = {d[N-1:0], 1'b0};
        case (shift_mode_e'(mode))
            SH_LSR: q = {1'b0, d[N:1]};
            SH_ASR: q = {d[N], d[N:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            SH_ROL: q = {d[N-1:0], d[N]};
`endif
            default: q = {d[N-1:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential shift engine: one bit position per clock, valid/ready in and out.
// Optional rotate mode is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq
    import shift_pkg::*;
#(
    parameter int N  = SHIFT_N_DEF,
    parameter int SW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N:0]    in_data,
    input  logic [SW-1:0] in_amt,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N:0]    out_data,
    output logic          busy
);

    shift_state_e  state_q, state_d;
    logic [N:0]    work_q, work_d;
    logic [N:0]    step;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;

    shift_step #(.N(N)) u_step (
        .d    (work_q),
        .mode (mode_q),
        .q    (step)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = in_amt;
                    mode_d  = in_mode;
                    state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - 1'b1;
                // last step is applied on the cycle the counter reads one
                if (cnt_q == SW'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases, reset abort, random ops.
// Expected results come from a shift-by-amount model, not a bit-step model.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    shift_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d,
                                         input int a, input logic [1:0] m);
        logic signed [7:0] s;
        logic [15:0] dd;
        s  = d;
        dd = {d, d} << (a % 8);
        case (m)
            2'd0: model = (a >= 8) ? 8'h00 : 8'(d << a);
            2'd1: model = (a >= 8) ? 8'h00 : 8'(d >> a);
            2'd2: model = 8'(s >>> a);
`ifdef SHIFT_SEQ_ROTATE_EN
            default: model = dd[15:8];
`else
            default: model = 8'(d << a);
`endif
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold==0 keeps out_ready high throughout; otherwise it stays low
    // for hold cycles after out_valid rises.
    task automatic run_op(input logic [7:0] d, input logic [2:0] a,
                          input logic [1:0] m, input int hold,
                          input logic [7:0] exp);
        int lat;
        logic [7:0] seen;
        chk("idle_in_ready", in_ready, 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_mode   = m;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_amt   = 3'($urandom);
        in_mode  = 2'($urandom);
        chk("accept_busy", busy, 1);
        chk("accept_in_ready", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("shift_in_ready", in_ready, 0);
            tick();
            lat++;
        end
        chk("latency", lat, 32'(a) + 1);
        chk("out_data", out_data, exp);
        seen = out_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, seen);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_busy", busy, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] ra;
        logic [1:0] rm;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);

        run_op(8'h81, 3'd3, 2'd0, 0, 8'h08);
        run_op(8'hA4, 3'd2, 2'd2, 0, 8'hE9);
        run_op(8'hA4, 3'd2, 2'd1, 0, 8'h29);
        run_op(8'h5C, 3'd0, 2'd2, 5, 8'h5C);
`ifdef SHIFT_SEQ_ROTATE_EN
        run_op(8'h81, 3'd1, 2'd3, 0, 8'h03);
`else
        run_op(8'h81, 3'd1, 2'd3, 0, 8'h02);
`endif

        // reset asserted in the third SHIFT cycle of a 7-step job
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_amt   = 3'd7;
        in_mode  = 2'd0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_valid", out_valid, 0);
            tick();
        end
        out_ready = 1'b0;
        run_op(8'h3C, 3'd4, 2'd1, 1, 8'h03);

        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            ra = 3'($urandom);
            rm = 2'($urandom);
            run_op(rd, ra, rm, int'($urandom_range(0, 3)),
                   model(rd, int'(ra), rm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
